// File: rtl/dru_pkg.sv
// dru_pkg: shared types, default sizes and width helpers for the data recovery unit.
package dru_pkg;
    typedef enum logic {HUNT, LOCKED} dru_state_e;
    localparam int DRU_OSR = 4;
    localparam int DRU_SPW = 8;
    function automatic int bpw(input int osr, input int spw);
        return spw / osr;
    endfunction
    function automatic int cnt_w(input int osr, input int spw);
        return $clog2(spw / osr + 2);
    endfunction
endpackage

// File: rtl/dru_phase_tracker_if.sv
// dru_phase_tracker_if: sample stream in, recovered bits and tracking status out.
// With DRU_PHASE_OVERRIDE_EN defined the phase force inputs are present.
interface dru_phase_tracker_if import dru_pkg::*; #(
    parameter int OSR = DRU_OSR,
    parameter int SPW = DRU_SPW
);
    localparam int BPW = bpw(OSR, SPW);
    localparam int CW  = cnt_w(OSR, SPW);
    localparam int PW  = $clog2(OSR);
    logic [SPW-1:0] din;
    logic           din_valid;
    logic [BPW:0]   dout;
    logic [CW-1:0]  dout_cnt;
    logic           dout_valid;
    logic [OSR-1:0] edge_flags;
    logic [PW-1:0]  phase;
    logic           locked;
`ifdef DRU_PHASE_OVERRIDE_EN
    logic           phase_force_en;
    logic [PW-1:0]  phase_force;
    modport master (output din, din_valid, phase_force_en, phase_force,
                    input dout, dout_cnt, dout_valid, edge_flags, phase, locked);
    modport slave  (input din, din_valid, phase_force_en, phase_force,
                    output dout, dout_cnt, dout_valid, edge_flags, phase, locked);
`else
    modport master (output din, din_valid,
                    input dout, dout_cnt, dout_valid, edge_flags, phase, locked);
    modport slave  (input din, din_valid,
                    output dout, dout_cnt, dout_valid, edge_flags, phase, locked);
`endif
endinterface

// File: rtl/dru_edge_detect.sv
// dru_edge_detect: registers each accepted word with the last sample of the word before,
// and folds sample-to-sample transitions onto their phase within the bit period.
module dru_edge_detect import dru_pkg::*; #(
    parameter int OSR = DRU_OSR,
    parameter int SPW = DRU_SPW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [SPW-1:0] din,
    input  logic           din_valid,
    output logic [SPW-1:0] sw,
    output logic           prev_last,
    output logic           sw_valid,
    output logic [OSR-1:0] edge_flags
);
    logic [SPW-1:0] edges;
    assign edges = sw ^ {sw[SPW-2:0], prev_last};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw        <= '0;
            prev_last <= 1'b0;
            sw_valid  <= 1'b0;
        end else begin
            sw_valid <= din_valid;
            if (din_valid) begin
                sw        <= din;
                prev_last <= sw[SPW-1];
            end
        end
    end
    always_comb begin
        edge_flags = '0;
        for (int i = 0; i < SPW; i++) edge_flags[i % OSR] = edge_flags[i % OSR] | edges[i];
    end
endmodule

// File: rtl/dru_phase_tracker.sv
// dru_phase_tracker: oversampled data recovery that votes on edge phases and steers sampling away from them.
// Defining DRU_PHASE_OVERRIDE_EN adds phase_force_en/phase_force to pin the phase manually.
module dru_phase_tracker import dru_pkg::*; #(
    parameter int OSR      = DRU_OSR,
    parameter int SPW      = DRU_SPW,
    parameter int WIN      = 16,
    parameter int LOCK_CNT = 4,
    parameter int VOTE_W   = 8
) (
    input logic clk,
    input logic rst,
    dru_phase_tracker_if.slave io
);
    localparam int BPW = bpw(OSR, SPW);
    localparam int CW  = cnt_w(OSR, SPW);
    localparam int PW  = $clog2(OSR);
    localparam int WW  = $clog2(WIN);
    localparam int SW  = $clog2(LOCK_CNT + 1);
    logic [SPW-1:0]    sw, shifted;
    logic              prev_last, sw_valid;
    logic [OSR-1:0]    ef;
    logic [VOTE_W-1:0] vote [OSR];
    logic [VOTE_W-1:0] vote_nx [OSR];
    logic [VOTE_W-1:0] best_v;
    logic [PW-1:0]     phase, best, d, ph_nx, frc_ph;
    logic              any, step_up, big, move, win_end, frc, frc_d, wrap_f, wrap_b, stable_hit;
    logic [WW-1:0]     wcnt;
    logic [SW-1:0]     stable;
    logic [BPW:0]      norm, dn;
    logic [CW-1:0]     cn;
    dru_state_e        state;

    dru_edge_detect #(.OSR(OSR), .SPW(SPW)) u_edge (
        .clk, .rst, .din(io.din), .din_valid(io.din_valid),
        .sw, .prev_last, .sw_valid, .edge_flags(ef)
    );

`ifdef DRU_PHASE_OVERRIDE_EN
    assign frc    = io.phase_force_en;
    assign frc_ph = io.phase_force;
`else
    assign frc    = 1'b0;
    assign frc_ph = '0;
`endif

    // Strict compare keeps the lowest phase on ties.
    always_comb begin
        best   = '0;
        best_v = '0;
        any    = 1'b0;
        for (int p = 0; p < OSR; p++) begin
            vote_nx[p] = vote[p] + VOTE_W'(ef[p] && vote[p] != '1);
            any        = any | (vote_nx[p] != '0);
            if (vote_nx[p] > best_v) begin
                best   = PW'(p);
                best_v = vote_nx[p];
            end
        end
    end

    // Distance to the target is taken modulo OSR; half-way ties step forward.
    assign d          = best + PW'(OSR / 2) - phase;
    assign step_up    = d <= PW'(OSR / 2);
    assign big        = step_up ? d > PW'(1) : d < PW'(OSR - 1);
    assign ph_nx      = step_up ? phase + PW'(1) : phase - PW'(1);
    assign win_end    = wcnt == WW'(WIN - 1);
    assign move       = win_end && any && d != '0 && !frc;
    assign stable_hit = stable >= SW'(LOCK_CNT - 1);
    assign shifted    = sw >> phase;

    always_comb begin
        norm = '0;
        for (int k = 0; k < BPW; k++) norm[k] = shifted[k * OSR];
    end

    // A phase wrap shortens or lengthens exactly one word to keep bit alignment.
    assign dn = wrap_f ? norm >> 1 : wrap_b ? {norm[BPW-1:0], prev_last} : norm;
    assign cn = wrap_f ? CW'(BPW - 1) : wrap_b ? CW'(BPW + 1) : CW'(BPW);
    assign io.phase  = phase;
    assign io.locked = state == LOCKED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io.dout       <= '0;
            io.dout_cnt   <= '0;
            io.dout_valid <= 1'b0;
            io.edge_flags <= '0;
            phase         <= PW'(OSR / 2);
            state         <= HUNT;
            vote          <= '{default: '0};
            wcnt          <= '0;
            stable        <= '0;
            wrap_f        <= 1'b0;
            wrap_b        <= 1'b0;
            frc_d         <= 1'b0;
        end else begin
            io.dout_valid <= sw_valid;
            frc_d         <= frc;
            if (sw_valid) begin
                io.dout       <= dn;
                io.dout_cnt   <= cn;
                io.edge_flags <= ef;
                wrap_f        <= move && step_up && phase == PW'(OSR - 1);
                wrap_b        <= move && !step_up && phase == '0;
                if (win_end) begin
                    vote <= '{default: '0};
                    wcnt <= '0;
                end else begin
                    vote <= vote_nx;
                    wcnt <= wcnt + 1'b1;
                end
                if (move) begin
                    phase  <= ph_nx;
                    stable <= '0;
                    if (big) state <= HUNT;
                end else if (win_end && any && !frc) begin
                    stable <= stable_hit ? SW'(LOCK_CNT) : stable + 1'b1;
                    if (stable_hit) state <= LOCKED;
                end
            end
            if (frc) begin
                phase  <= frc_ph;
                state  <= HUNT;
                stable <= '0;
                wrap_f <= 1'b0;
                wrap_b <= 1'b0;
            end else if (frc_d) begin
                vote <= '{default: '0};
                wcnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dru_phase_tracker.sv
// tb_dru_phase_tracker: directed stimulus with a behavioural reference model feeding a scoreboard.
module tb_dru_phase_tracker;
    localparam int OSR = 4, SPW = 8, WIN = 4, LOCK_CNT = 3;
    typedef struct packed {
        logic [2:0] dout;
        logic [1:0] cnt;
        logic [3:0] ef;
        logic [1:0] ph;
        logic       lk;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t q[$];
    exp_t mon_e;
    int errors = 0, checks = 0, nsent = 0, nvalid = 0;
    logic m_pl, m_lk;
    int m_ph, m_wcnt, m_stable, m_pend;
    int m_vote[OSR];

    always #5 clk = ~clk;

    dru_phase_tracker_if #(.OSR(OSR), .SPW(SPW)) dif ();
    dru_phase_tracker #(.OSR(OSR), .SPW(SPW), .WIN(WIN), .LOCK_CNT(LOCK_CNT), .VOTE_W(8)) dut (
        .clk(clk), .rst(rst), .io(dif)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pl = 1'b0; m_lk = 1'b0;
        m_ph = 2; m_wcnt = 0; m_stable = 0; m_pend = 0;
        for (int p = 0; p < OSR; p++) m_vote[p] = 0;
    endtask

    task automatic model_word(input logic [7:0] d);
        logic [8:0] ext;
        logic [7:0] sh;
        logic [3:0] ef;
        logic [2:0] dv;
        int cnt, best, fd, nph;
        ext = {d, m_pl};
        ef = '0;
        for (int i = 0; i < 8; i++) if (ext[i+1] != ext[i]) ef[i % 4] = 1'b1;
        sh = d >> m_ph;
        if (m_pend == 1) begin dv = {2'b00, sh[4]}; cnt = 1; end
        else if (m_pend == 2) begin dv = {sh[4], sh[0], m_pl}; cnt = 3; end
        else begin dv = {1'b0, sh[4], sh[0]}; cnt = 2; end
        m_pend = 0;
        m_pl = d[7];
        for (int p = 0; p < OSR; p++) if (ef[p] && m_vote[p] < 255) m_vote[p]++;
        m_wcnt++;
        if (m_wcnt == WIN) begin
            m_wcnt = 0;
            best = 0;
            for (int p = 1; p < OSR; p++) if (m_vote[p] > m_vote[best]) best = p;
            if (m_vote[best] != 0) begin
                fd = ((best + 2) % 4 - m_ph + 4) % 4;
                if (fd == 0) begin
                    m_stable++;
                    if (m_stable >= LOCK_CNT) m_lk = 1'b1;
                end else begin
                    nph = (fd <= 2) ? (m_ph + 1) % 4 : (m_ph + 3) % 4;
                    if (fd == 2) m_lk = 1'b0;
                    m_pend = (m_ph == 3 && nph == 0) ? 1 : (m_ph == 0 && nph == 3) ? 2 : 0;
                    m_ph = nph;
                    m_stable = 0;
                end
            end
            for (int p = 0; p < OSR; p++) m_vote[p] = 0;
        end
        q.push_back('{dout: dv, cnt: cnt[1:0], ef: ef, ph: m_ph[1:0], lk: m_lk});
        nsent++;
    endtask

    task automatic send(input logic [7:0] d);
        dif.din = d;
        dif.din_valid = 1'b1;
        model_word(d);
        @(posedge clk); #1;
        dif.din_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        check("drain_empty", q.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst && dif.dout_valid) begin
            nvalid++;
            if (q.size() == 0) check("spurious_valid", dif.dout_valid, 0);
            else begin
                mon_e = q.pop_front();
                check("dout", dif.dout, mon_e.dout);
                check("dout_cnt", dif.dout_cnt, mon_e.cnt);
                check("edge_flags", dif.edge_flags, mon_e.ef);
                check("phase", dif.phase, mon_e.ph);
                check("locked", dif.locked, mon_e.lk);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.din = '0;
        dif.din_valid = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_dout", dif.dout, 0);
        check("rst_dout_cnt", dif.dout_cnt, 0);
        check("rst_dout_valid", dif.dout_valid, 0);
        check("rst_edge_flags", dif.edge_flags, 0);
        check("rst_phase", dif.phase, 2);
        check("rst_locked", dif.locked, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) send(8'h00);
        repeat (12) send(8'hF0);
        drain();
        check("lock_after_3_windows", dif.locked, 1);
        repeat (8) send(8'hE1);
        drain();
        check("phase_to_3", dif.phase, 3);
        repeat (8) send(8'hC3);
        repeat (8) send(8'hE1);
        repeat (4) send(8'h87);
        drain();
        check("unlock_large_move", dif.locked, 0);
        repeat (8) begin
            send(8'hF0);
            @(posedge clk); #1;
        end
        repeat (14) send(8'hF0);
        drain();
        check("relock", dif.locked, 1);
        check("relock_phase", dif.phase, 2);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("midrst_dout", dif.dout, 0);
        check("midrst_dout_cnt", dif.dout_cnt, 0);
        check("midrst_edge_flags", dif.edge_flags, 0);
        check("midrst_phase", dif.phase, 2);
        check("midrst_locked", dif.locked, 0);
        q.delete();
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) send(8'hE1);
        drain();
        check("post_rst_phase", dif.phase, 3);
        check("valid_count", nvalid, nsent);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dru_phase_tracker.md
Name: dru_phase_tracker

Overview:
- Parametrised successor to the 4x-oversampled 8-sample edge detector.
- Takes oversampled serial words from the ISERDES sample stage and locates per-phase transitions.
- Integrates edge votes over a window and steers the sampling phase away from the dominant edge phase.
- Emits recovered bits with a variable count (BPW-1, BPW or BPW+1) to absorb phase wrap between sender and local clocks.

Parameters:
- OSR, 4, oversampling ratio: samples per bit; power of two, >= 4.
- SPW, 8, samples per input word; multiple of OSR. BPW = SPW/OSR is the nominal bits per word.
- WIN, 16, valid words per vote integration window; >= 2.
- LOCK_CNT, 4, consecutive no-move windows required to assert locked.
- VOTE_W, 8, width of each saturating per-phase vote counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- din  in  SPW  oversampled word; bit 0 is the earliest sample.
- din_valid  in  1  din qualifier; invalid cycles are ignored entirely.
- dout  out  BPW+1  recovered bits; dout[0] is the earliest; bits at and above dout_cnt are 0.
- dout_cnt  out  $clog2(BPW+2)  number of valid bits in dout.
- dout_valid  out  1  one-cycle strobe per accepted word.
- edge_flags  out  OSR  per-phase edge flags of the last accepted word.
- phase  out  $clog2(OSR)  current sampling phase.
- locked  out  1  phase lock indicator.

Behaviour:
- Reset values: all outputs 0; phase = OSR/2; prev_last = 0; vote counters, word counter and stable counter 0; state HUNT.
- Stage 1 (cycle after din_valid): din is registered into sw, together with prev_last (sw[SPW-1] of the previous accepted word).
- Stage 2 (registered, 2 cycles after din_valid): dout, dout_cnt, dout_valid and edge_flags update.
- Edge rule: sample i has an edge when s[i] != s[i-1], where s[-1] = prev_last. edge_flags[p] = OR of the edges at i with i mod OSR == p.
- Votes: each asserted edge_flags[p] increments vote[p], saturating at 2^VOTE_W-1.
- Window end: on the WIN-th accepted word, find the phase e with the maximum vote; ties go to the lowest index.
  - Target phase t = (e + OSR/2) mod OSR.
  - If every vote is 0: no move, and the stable counter is held.
  - If t != phase: step phase by one toward t along the shorter modular path. When the path is exactly OSR/2 long, step +1.
  - All votes and the word counter clear. The new phase applies starting with the next accepted word.
- Normal data: dout[k] = sw[phase + k*OSR] for k = 0..BPW-1; dout_cnt = BPW.
- Forward wrap (OSR-1 -> 0): the first word at the new phase drops sample 0. dout holds the samples at OSR, 2*OSR, ...; dout_cnt = BPW-1.
- Backward wrap (0 -> OSR-1): the first word at the new phase prepends the previous word's sample SPW-1. dout[0] is that sample, followed by the BPW normal bits; dout_cnt = BPW+1.
- State machine:
  - HUNT -> LOCKED after LOCK_CNT consecutive window ends with no move and nonzero votes.
  - LOCKED -> HUNT on any window end that moves the phase by the shorter path with length > 1 (large excursion).
  - A 1-step move in LOCKED keeps lock but resets the stable counter.
  - locked = (state == LOCKED), registered.
- din_valid low: no pipeline advance, no vote change, dout_valid = 0, all registers hold.
- Reset mid-operation: immediate return to reset values. Partial windows and pending wraps are discarded.

Optional Feature:
- Macro: DRU_PHASE_OVERRIDE_EN.
- When defined, two inputs are added: phase_force_en (1 bit) and phase_force ($clog2(OSR) bits).
  - While phase_force_en = 1, phase = phase_force and is applied on the next accepted word.
  - No wrap count adjustment is made for forced phase changes.
  - Votes keep accumulating, but window ends make no move; state is forced to HUNT.
  - On deassertion, tracking resumes from the forced phase with a fresh window.
- When not defined, those ports are absent and phase is fully automatic.

Decomposition:
- Shared package dru_pkg:
  - state enum dru_state_e {HUNT, LOCKED};
  - localparam function helpers for BPW and count width;
  - default OSR/SPW constants.
- Sub-module dru_edge_detect: registered sw/prev_last stage plus combinational edge_flags; parametrised by OSR and SPW.

Test Plan (OSR=4, SPW=8, WIN=4, LOCK_CNT=3):
- Reset, then constant din=8'h00 for 20 words -> edge_flags=0, phase stays 2, locked=0, dout_cnt=2 and dout=0 each word.
- Repeating din=8'hF0 (edges at phase 0) -> after the first window phase stays 2; locked=1 after 3 windows; dout=2'b10 with dout_cnt=2.
- Pattern with edges at phase 1, starting from phase 2 -> phase moves to 3 after one window; dout_cnt remains 2.
- Slow drift that forces phase 3 -> 0 -> exactly one word with dout_cnt=1, then back to 2. Reverse drift 0 -> 3 -> one word with dout_cnt=3, with dout[0] equal to the previous word's sample 7.
- din_valid toggled 1/0 every cycle with pattern 8'hF0 -> window end after 4 valid words (8 cycles); no dout_valid on invalid cycles.
- Assert rst mid-window while locked=1 -> all outputs 0 and phase=2 in the same cycle; the next window starts counting from 0.
